// File: rtl/aes_pkg.sv
// aes_pkg: shared AES GF(2^8) helpers and FSM state type
package aes_pkg;

    localparam logic [8:0] AES_POLY = 9'h11b;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY[7:0] : 8'h00);
    endfunction

    function automatic logic [7:0] x2(input logic [7:0] b);
        return xtime(b);
    endfunction

    function automatic logic [7:0] x3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] x4(input logic [7:0] b);
        return xtime(xtime(b));
    endfunction

    function automatic logic [7:0] x8(input logic [7:0] b);
        return xtime(x4(b));
    endfunction

    function automatic logic [7:0] x9(input logic [7:0] b);
        return x8(b) ^ b;
    endfunction

    function automatic logic [7:0] xb(input logic [7:0] b);
        return x8(b) ^ x2(b) ^ b;
    endfunction

    function automatic logic [7:0] xd(input logic [7:0] b);
        return x8(b) ^ x4(b) ^ b;
    endfunction

    function automatic logic [7:0] xe(input logic [7:0] b);
        return x8(b) ^ x4(b) ^ x2(b);
    endfunction

endpackage

// File: rtl/mix_single_column.sv
// mix_single_column: combinational (Inv)MixColumns of one column, row 0 in bits [31:24]
module mix_single_column
    import aes_pkg::*;
(
    input  logic        inverse,
    input  logic [31:0] col_i,
    output logic [31:0] col_o
);

    logic [7:0] a [4];

    for (genvar i = 0; i < 4; i++) begin : g_byte
        assign a[i] = col_i[31-8*i -: 8];
        assign col_o[31-8*i -: 8] = inverse
            ? xe(a[i]) ^ xb(a[(i+1)%4]) ^ xd(a[(i+2)%4]) ^ x9(a[(i+3)%4])
            : x2(a[i]) ^ x3(a[(i+1)%4]) ^ a[(i+2)%4] ^ a[(i+3)%4];
    end

endmodule

// File: rtl/mix_columns_seq.sv
// mix_columns_seq: iterative AES (Inv)MixColumns over a row-major state, COLS_PER_CYCLE columns per clock
module mix_columns_seq
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         In_Valid,
    output logic         In_Ready,
    input  logic [0:127] In_State,
    input  logic         In_Inverse,
    output logic         Out_Valid,
    input  logic         Out_Ready,
    output logic [0:127] Out_State
);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
        $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);

    state_e       state_q, state_d;
    logic [1:0]   col_q, col_d;
    logic [0:127] work_q, work_d;
    logic         inv_q, inv_d;

    logic [1:0]   col_idx [COLS_PER_CYCLE];
    logic [31:0]  col_in  [COLS_PER_CYCLE];
    logic [31:0]  col_out [COLS_PER_CYCLE];

    // byte (r, c) sits at bit offset 32*r + 8*c of the row-major working register
    for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_col
        assign col_idx[j] = col_q + 2'(j);
        assign col_in[j]  = {work_q[{2'd0, col_idx[j], 3'd0} +: 8],
                             work_q[{2'd1, col_idx[j], 3'd0} +: 8],
                             work_q[{2'd2, col_idx[j], 3'd0} +: 8],
                             work_q[{2'd3, col_idx[j], 3'd0} +: 8]};
        mix_single_column u_mix (
            .inverse (inv_q),
            .col_i   (col_in[j]),
            .col_o   (col_out[j])
        );
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        work_d  = work_q;
        inv_d   = inv_q;
        case (state_q)
            IDLE: if (In_Valid) begin
                state_d = BUSY;
                col_d   = '0;
                work_d  = In_State;
                inv_d   = In_Inverse;
            end
            BUSY: begin
                for (int c = 0; c < COLS_PER_CYCLE; c++)
                    for (int r = 0; r < 4; r++)
                        work_d[{2'(r), col_idx[c], 3'd0} +: 8] = col_out[c][{~2'(r), 3'd7} -: 8];
                col_d   = col_q + STEP;
                state_d = (col_q == LAST) ? DONE : BUSY;
            end
            DONE:    state_d = Out_Ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            col_q   <= '0;
            work_q  <= '0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            work_q  <= work_d;
            inv_q   <= inv_d;
        end
    end

    assign In_Ready  = (state_q == IDLE) && !RST;
    assign Out_Valid = (state_q == DONE) && !RST;
    assign Out_State = work_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// tb_mix_columns_seq: directed FIPS-197 vectors plus randomised stream on COLS_PER_CYCLE = 1, 2, 4
module tb_mix_columns_seq;

    // FIPS-197 lists states column by column; the bus is row-major, so vectors go through tr()
    localparam logic [0:127] FWD_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [0:127] FWD_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [0:127] R2_IN   = 128'h49db873b453953897f02d2f177de961a;
    localparam logic [0:127] R2_OUT  = 128'h584dcaf11b4b5aacdbe7caa81b6bb0e5;

    logic         clk;
    logic         rst;
    logic         in_valid   [3];
    logic         in_ready   [3];
    logic [0:127] in_state   [3];
    logic         in_inverse [3];
    logic         out_valid  [3];
    logic         out_ready  [3];
    logic [0:127] out_state  [3];

    int n_chk  = 0;
    int n_fail = 0;
    int lat;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mix_columns_seq #(.COLS_PER_CYCLE(1 << g)) u_dut (
            .CLK        (clk),
            .RST        (rst),
            .In_Valid   (in_valid[g]),
            .In_Ready   (in_ready[g]),
            .In_State   (in_state[g]),
            .In_Inverse (in_inverse[g]),
            .Out_Valid  (out_valid[g]),
            .Out_Ready  (out_ready[g]),
            .Out_State  (out_state[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time %0t reached, limit 2000000", $time);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [0:127] ref_mix(input logic [0:127] s, input logic inv);
        logic [7:0]   co [4];
        logic [7:0]   acc;
        logic [0:127] o = '0;
        if (inv) co = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     co = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc ^= gmul(co[(k - r + 4) % 4], s[7'(32*k + 8*c) +: 8]);
                o[7'(32*r + 8*c) +: 8] = acc;
            end
        return o;
    endfunction

    function automatic logic [0:127] tr(input logic [0:127] v);
        logic [0:127] o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[7'(32*r + 8*c) +: 8] = v[7'(32*c + 8*r) +: 8];
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int i, input logic [0:127] s, input logic inv);
        int t = 0;
        while (!in_ready[i] && t < 50) begin
            tick();
            t++;
        end
        if (!in_ready[i]) check($sformatf("send_timeout%0d", i), 128'(in_ready[i]), 128'd1);
        in_state[i]   = s;
        in_inverse[i] = inv;
        in_valid[i]   = 1'b1;
        tick();
        in_valid[i]   = 1'b0;
    endtask

    task automatic wait_out(input int i, output int l);
        l = 0;
        while (!out_valid[i] && l < 50) begin
            tick();
            l++;
        end
        if (!out_valid[i]) check($sformatf("out_timeout%0d", i), 128'(out_valid[i]), 128'd1);
    endtask

    task automatic release_out(input int i);
        out_ready[i] = 1'b1;
        tick();
        out_ready[i] = 1'b0;
    endtask

    task automatic rand_stream(input int i, input int n);
        logic [0:127] s;
        logic         inv;
        int           l;
        for (int t = 0; t < n; t++) begin
            s   = {$urandom, $urandom, $urandom, $urandom};
            inv = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 1)) tick();
            send(i, s, inv);
            wait_out(i, l);
            check($sformatf("rand_lat%0d", i), 128'(l), 128'(4 >> i));
            repeat ($urandom_range(0, 2)) tick();
            check($sformatf("rand_out%0d", i), out_state[i], ref_mix(s, inv));
            release_out(i);
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid[i]   = 1'b0;
            in_state[i]   = '0;
            in_inverse[i] = 1'b0;
            out_ready[i]  = 1'b0;
        end
        tick();
        tick();
        check("rst_in_ready", 128'(in_ready[0]), 128'd0);
        check("rst_out_valid", 128'(out_valid[0]), 128'd0);
        check("rst_out_state", out_state[0], 128'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 128'(in_ready[0]), 128'd1);

        for (int i = 0; i < 3; i++) begin
            send(i, tr(FWD_IN), 1'b0);
            wait_out(i, lat);
            check($sformatf("fwd_latency%0d", i), 128'(lat), 128'(4 >> i));
            check($sformatf("fwd_out%0d", i), out_state[i], tr(FWD_OUT));
            release_out(i);
            check($sformatf("fwd_back_idle%0d", i), 128'(in_ready[i]), 128'd1);
        end

        // Out_Ready held high through BUSY must not cut the operation short
        out_ready[0] = 1'b1;
        send(0, tr(FWD_OUT), 1'b1);
        wait_out(0, lat);
        check("inv_latency", 128'(lat), 128'd4);
        check("inv_out", out_state[0], tr(FWD_IN));
        tick();
        out_ready[0] = 1'b0;
        check("inv_back_idle", 128'(in_ready[0]), 128'd1);

        send(0, tr(FWD_IN), 1'b0);
        wait_out(0, lat);
        for (int k = 0; k < 5; k++) begin
            check("bp_out_valid", 128'(out_valid[0]), 128'd1);
            check("bp_in_ready", 128'(in_ready[0]), 128'd0);
            check("bp_out_state", out_state[0], tr(FWD_OUT));
            tick();
        end
        release_out(0);
        check("bp_back_idle", 128'(in_ready[0]), 128'd1);
        check("bp_valid_drop", 128'(out_valid[0]), 128'd0);

        send(0, tr(FWD_IN), 1'b0);
        in_valid[0]   = 1'b1;
        in_inverse[0] = 1'b1;
        in_state[0]   = tr(R2_IN);
        wait_out(0, lat);
        in_valid[0]   = 1'b0;
        check("midchg_out", out_state[0], tr(FWD_OUT));
        release_out(0);

        send(0, tr(R2_IN), 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rstb_in_ready", 128'(in_ready[0]), 128'd1);
        check("rstb_out_valid", 128'(out_valid[0]), 128'd0);
        check("rstb_out_state", out_state[0], 128'd0);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("rstb_no_out", 128'(out_valid[0]), 128'd0);
        end
        send(0, tr(R2_IN), 1'b0);
        wait_out(0, lat);
        check("r2_latency", 128'(lat), 128'd4);
        check("r2_out", out_state[0], tr(R2_OUT));
        release_out(0);

        fork
            rand_stream(0, 4000);
            rand_stream(1, 3000);
            rand_stream(2, 3000);
        join

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mix_columns_seq.md
MIX_COLUMNS_SEQ -- requirements
Module: mix_columns_seq

Interface
REQ-001 SHALL have parameter COLS_PER_CYCLE, default 1, meaning columns transformed per cycle; legal values 1, 2, 4.
REQ-002 SHALL have port CLK, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port RST, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have port In_Valid, input, 1, meaning In_State and In_Inverse are valid.
REQ-005 SHALL have port In_Ready, output, 1, meaning the block accepts a state this cycle.
REQ-006 SHALL have port In_State, input, [0:127], the state after ShiftRows (or after InvShiftRows), row-major: byte k = bits [8k:8k+7], row k/4, column k%4.
REQ-007 SHALL have port In_Inverse, input, 1, where 0 = MixColumns and 1 = InvMixColumns.
REQ-008 SHALL have port Out_Valid, output, 1, meaning Out_State holds a completed result.
REQ-009 SHALL have port Out_Ready, input, 1, the consumer's acceptance of the result.
REQ-010 SHALL have port Out_State, output, [0:127], the result in the same row-major layout.

Function
REQ-011 SHALL implement a 3-state FSM: IDLE, BUSY and DONE.
REQ-012 SHALL drive In_Ready = 1 only in IDLE.
REQ-013 SHALL drive Out_Valid = 1 only in DONE.
REQ-014 SHALL, in IDLE with In_Valid=1, capture In_State and In_Inverse into internal registers, clear the column counter and go to BUSY.
REQ-015 SHALL ignore In_State and In_Inverse while not in IDLE; a mode change mid-operation has no effect.
REQ-016 SHALL, in BUSY, replace COLS_PER_CYCLE columns per cycle, in ascending column order (column c = bytes c, 4+c, 8+c, 12+c).
REQ-017 SHALL compute forward columns with matrix rows {02 03 01 01} rotated, in GF(2^8) modulo 0x11B.
REQ-018 SHALL compute inverse columns with matrix rows {0E 0B 0D 09} rotated.
REQ-019 SHALL use a column counter that is 2 bits wide, advances by COLS_PER_CYCLE, and wraps to 0.
REQ-020 SHALL go from BUSY to DONE on the cycle in which the last column is written.
REQ-021 SHALL meet this latency: N = 4/COLS_PER_CYCLE; Out_Valid rises exactly N clock edges after the accepting edge.
REQ-022 SHALL hold Out_State and Out_Valid stable in DONE until Out_Ready=1.
REQ-023 SHALL, on an edge with Out_Ready=1 in DONE, return to IDLE; In_Ready is high on the following cycle. No back-to-back accept in the same cycle.
REQ-024 SHALL ignore Out_Ready outside DONE.
REQ-025 SHALL drive Out_State continuously from the working register; its value outside DONE is don't-care for consumers.

Reset
REQ-026 SHALL, with RST=1 at a clock edge, set the FSM to IDLE, the column counter to 0, the working register to 0 and the mode register to 0, regardless of state.
REQ-027 SHALL give reset priority over all handshakes.
REQ-028 SHALL, when reset is asserted in BUSY or DONE, discard the in-flight state with no output.
REQ-029 SHALL hold In_Ready=0 and Out_Valid=0 while RST=1, and hold In_Ready=1 on the first cycle after reset deasserts.

Structure
REQ-030 SHALL take the following from shared package aes_pkg:
- xtime function and GF(2^8) constant-multiply functions (x2, x3, x9, xB, xD, xE)
- AES reduction polynomial constant 0x11B
- the FSM state enum
REQ-031 SHALL instantiate COLS_PER_CYCLE copies of one combinational sub-module, mix_single_column: 32-bit column in, inverse select, 32-bit column out.
REQ-032 SHALL stop elaboration with an error for any COLS_PER_CYCLE outside {1, 2, 4}.

Verification
REQ-033 SHALL cover forward mode with the FIPS-197 vector: In_State=d4bf5d30e0b452aeb84111f11e2798e5, Inverse=0 -> Out_State=046681e5e0cb199a48f8d37a28062 64c, with Out_Valid exactly N cycles after accept, for each COLS_PER_CYCLE in 1, 2, 4.
REQ-034 SHALL cover inverse mode: In_State=046681e5e0cb199a48f8d37a2806264c, Inverse=1 -> Out_State=d4bf5d30e0b452aeb84111f11e2798e5.
REQ-035 SHALL cover backpressure: Out_Ready=0 for 5 cycles -> Out_State stable, Out_Valid=1, In_Ready=0 throughout; then Out_Ready=1 -> IDLE next cycle.
REQ-036 SHALL cover In_Inverse toggled and In_State changed during BUSY -> result still equals the forward vector 046681e5...
REQ-037 SHALL cover RST=1 for one cycle mid-BUSY -> next cycle In_Ready=1 and Out_Valid=0, with no output; a fresh vector 49db873b45395389 7f02d2f177de961a then gives 584dcaf11b4b5aacdbe7caa81b6bb0e5.
REQ-038 SHALL check a random vector stream against a reference model in both modes, with In_Valid/Out_Ready randomised, over 10000 transactions and zero mismatches.
